// File: rtl/top_if_pkg.sv
// rtl/top_if_pkg.sv - shared constants and state encoding for the instruction-fetch stage
package top_if_pkg;

    localparam int LENGTH_INSTRUCTION = 32;
    localparam int CANT_BITS_ADDR     = 11;
    localparam int RAM_DEPTH          = 2 ** CANT_BITS_ADDR;

    localparam logic [LENGTH_INSTRUCTION-1:0] HALT_INSTRUCTION = 32'hFFFF_FFFF;
    localparam logic [LENGTH_INSTRUCTION-1:0] NOP_INSTRUCTION  = 32'h0000_0000;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } if_state_e;

endpackage

// File: rtl/top_if_memoria_programa.sv
// rtl/top_if_memoria_programa.sv - program memory, one synchronous write port and one asynchronous read port
module memoria_programa
    import top_if_pkg::*;
(
    input  logic                          i_clock,
    input  logic                          i_write_enable,
    input  logic [CANT_BITS_ADDR-1:0]     i_write_addr,
    input  logic [LENGTH_INSTRUCTION-1:0] i_write_data,
    input  logic [CANT_BITS_ADDR-1:0]     i_read_addr,
    output logic [LENGTH_INSTRUCTION-1:0] o_read_data
);

    logic [LENGTH_INSTRUCTION-1:0] mem_q [RAM_DEPTH];

    // Debug-unit load port; contents survive reset on purpose.
    always_ff @(posedge i_clock) begin
        if (i_write_enable) begin
            mem_q[i_write_addr] <= i_write_data;
        end
    end

    assign o_read_data = mem_q[i_read_addr];

endmodule

// File: rtl/top_if.sv
// rtl/top_if.sv - MIPS instruction-fetch stage: PC, program memory and IF/ID register
module top_if
    import top_if_pkg::*;
(
    input  logic                          i_clock,
    input  logic                          i_soft_reset,
    input  logic                          i_enable_pipeline,
    input  logic                          i_stall,
    input  logic                          i_branch_control,
    input  logic [CANT_BITS_ADDR-1:0]     i_branch_dir,
    input  logic                          i_write_mem,
    input  logic [CANT_BITS_ADDR-1:0]     i_addr_mem,
    input  logic [LENGTH_INSTRUCTION-1:0] i_data_mem,
    output logic [LENGTH_INSTRUCTION-1:0] o_instruction,
    output logic [CANT_BITS_ADDR-1:0]     o_out_adder_pc,
    output logic [CANT_BITS_ADDR-1:0]     o_pc,
    output logic                          o_halted
);

    if_state_e                     state_q, state_d;
    logic [CANT_BITS_ADDR-1:0]     pc_q, pc_d;
    logic [LENGTH_INSTRUCTION-1:0] instr_q, instr_d;
    logic [CANT_BITS_ADDR-1:0]     adder_q, adder_d;

    logic [LENGTH_INSTRUCTION-1:0] fetch_word;
    logic [CANT_BITS_ADDR-1:0]     pc_plus_one;
    logic                          mem_we;

    // Loads only while frozen, and reset wins over a coincident load.
    assign mem_we = i_write_mem & ~i_enable_pipeline & ~i_soft_reset;

    memoria_programa u_memoria_programa (
        .i_clock        (i_clock),
        .i_write_enable (mem_we),
        .i_write_addr   (i_addr_mem),
        .i_write_data   (i_data_mem),
        .i_read_addr    (pc_q),
        .o_read_data    (fetch_word)
    );

    // Wraps naturally at the top of the address space.
    assign pc_plus_one = pc_q + {{(CANT_BITS_ADDR-1){1'b0}}, 1'b1};

    // Next-state: freeze, stall, redirect, halted-hold, halt-capture, normal fetch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        adder_d = adder_q;
        if (!i_enable_pipeline || i_stall) begin
            // hold everything
        end else if (i_branch_control) begin
            // A redirect from decode is older than any fetched HALT.
            pc_d    = i_branch_dir;
            instr_d = NOP_INSTRUCTION;
            adder_d = '0;
            state_d = ST_RUN;
        end else if (state_q == ST_HALTED) begin
            // hold until a redirect or reset
        end else if (fetch_word == HALT_INSTRUCTION) begin
            instr_d = HALT_INSTRUCTION;
            adder_d = pc_plus_one;
            state_d = ST_HALTED;
        end else begin
            instr_d = fetch_word;
            adder_d = pc_plus_one;
            pc_d    = pc_plus_one;
        end
    end

    // State, PC and IF/ID registers with synchronous reset.
    always_ff @(posedge i_clock) begin
        if (i_soft_reset) begin
            state_q <= ST_RUN;
            pc_q    <= '0;
            instr_q <= NOP_INSTRUCTION;
            adder_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            adder_q <= adder_d;
        end
    end

    assign o_instruction  = instr_q;
    assign o_out_adder_pc = adder_q;
    assign o_pc           = pc_q;
    assign o_halted       = (state_q == ST_HALTED);

endmodule

// File: tb/tb_top_if.sv
// tb/tb_top_if.sv - scoreboard bench for the instruction-fetch stage
module tb_top_if;

    logic        i_clock = 1'b0;
    logic        i_soft_reset;
    logic        i_enable_pipeline;
    logic        i_stall;
    logic        i_branch_control;
    logic [10:0] i_branch_dir;
    logic        i_write_mem;
    logic [10:0] i_addr_mem;
    logic [31:0] i_data_mem;
    logic [31:0] o_instruction;
    logic [10:0] o_out_adder_pc;
    logic [10:0] o_pc;
    logic        o_halted;

    typedef struct {
        logic [31:0] instr;
        logic [10:0] adder;
        logic [10:0] pc;
        logic        halted;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP  = 32'h0000_0000;

    top_if dut (
        .i_clock           (i_clock),
        .i_soft_reset      (i_soft_reset),
        .i_enable_pipeline (i_enable_pipeline),
        .i_stall           (i_stall),
        .i_branch_control  (i_branch_control),
        .i_branch_dir      (i_branch_dir),
        .i_write_mem       (i_write_mem),
        .i_addr_mem        (i_addr_mem),
        .i_data_mem        (i_data_mem),
        .o_instruction     (o_instruction),
        .o_out_adder_pc    (o_out_adder_pc),
        .o_pc              (o_pc),
        .o_halted          (o_halted)
    );

    always #5 i_clock = ~i_clock;

    // Monitor: every negedge, compare the DUT against the oldest pending expectation.
    always @(negedge i_clock) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (o_instruction !== e.instr || o_out_adder_pc !== e.adder ||
                o_pc !== e.pc || o_halted !== e.halted) begin
                failures++;
                $display("FAIL %s: got instr=%h adder=%h pc=%h halted=%b expected instr=%h adder=%h pc=%h halted=%b",
                         e.name, o_instruction, o_out_adder_pc, o_pc, o_halted,
                         e.instr, e.adder, e.pc, e.halted);
            end
        end
    end

    // Drive one cycle of inputs, let the edge happen, then queue the expected post-edge state.
    task automatic step(input logic rst, input logic en, input logic stall,
                        input logic br, input logic [10:0] dir,
                        input logic wr, input logic [10:0] waddr, input logic [31:0] wdata,
                        input logic [31:0] e_instr, input logic [10:0] e_adder,
                        input logic [10:0] e_pc, input logic e_halted, input string name);
        exp_t e;
        i_soft_reset      = rst;
        i_enable_pipeline = en;
        i_stall           = stall;
        i_branch_control  = br;
        i_branch_dir      = dir;
        i_write_mem       = wr;
        i_addr_mem        = waddr;
        i_data_mem        = wdata;
        @(posedge i_clock);
        #1;
        e.instr  = e_instr;
        e.adder  = e_adder;
        e.pc     = e_pc;
        e.halted = e_halted;
        e.name   = name;
        exp_q.push_back(e);
    endtask

    // Normal enabled cycle, no stall/branch/write.
    task automatic run(input logic [31:0] ei, input logic [10:0] ea, input logic [10:0] ep,
                       input logic eh, input string name);
        step(1'b0, 1'b1, 1'b0, 1'b0, 11'd0, 1'b0, 11'd0, 32'd0, ei, ea, ep, eh, name);
    endtask

    task automatic load(input logic [10:0] addr, input logic [31:0] data);
        i_soft_reset      = 1'b0;
        i_enable_pipeline = 1'b0;
        i_stall           = 1'b0;
        i_branch_control  = 1'b0;
        i_write_mem       = 1'b1;
        i_addr_mem        = addr;
        i_data_mem        = data;
        @(posedge i_clock);
        #1;
        i_write_mem = 1'b0;
    endtask

    initial begin
        i_soft_reset = 1'b1; i_enable_pipeline = 1'b0; i_stall = 1'b0;
        i_branch_control = 1'b0; i_branch_dir = '0; i_write_mem = 1'b0;
        i_addr_mem = '0; i_data_mem = '0;

        step(1, 0, 0, 0, 0, 0, 0, 0, NOP, 11'd0, 11'd0, 0, "reset_state");

        load(11'd0,  32'h2001_0005);
        load(11'd1,  32'h2002_0007);
        load(11'd2,  32'h0022_1820);
        load(11'd3,  HALT);
        load(11'd4,  32'h1111_0004);
        load(11'd5,  32'h1111_0005);
        load(11'd6,  32'h1111_0006);
        load(11'd7,  HALT);
        load(11'h10, 32'hA000_0010);
        load(11'h20, 32'h2222_0020);
        load(11'h30, 32'h3333_0030);
        load(11'h7FF, 32'h7FF0_07FF);

        // Straight-line program ending in HALT
        run(32'h2001_0005, 11'd1, 11'd1, 0, "seq_w0");
        run(32'h2002_0007, 11'd2, 11'd2, 0, "seq_w1");
        run(32'h0022_1820, 11'd3, 11'd3, 0, "seq_w2");
        run(HALT,          11'd4, 11'd3, 1, "seq_halt");
        run(HALT,          11'd4, 11'd3, 1, "halt_hold");

        // Branch at PC=2
        step(1, 1, 0, 0, 0, 0, 0, 0, NOP, 11'd0, 11'd0, 0, "reset_for_branch");
        run(32'h2001_0005, 11'd1, 11'd1, 0, "br_w0");
        run(32'h2002_0007, 11'd2, 11'd2, 0, "br_w1");
        step(0, 1, 0, 1, 11'h10, 0, 0, 0, NOP, 11'd0, 11'h10, 0, "branch_nop");
        run(32'hA000_0010, 11'h11, 11'h11, 0, "branch_target");
        step(0, 0, 0, 1, 11'h55, 0, 0, 0, 32'hA000_0010, 11'h11, 11'h11, 0, "disabled_hold");

        // Stall at PC=5
        step(0, 1, 0, 1, 11'd4, 0, 0, 0, NOP, 11'd0, 11'd4, 0, "branch_to_4");
        run(32'h1111_0004, 11'd5, 11'd5, 0, "fetch_4");
        step(0, 1, 1, 0, 0, 0, 0, 0, 32'h1111_0004, 11'd5, 11'd5, 0, "stall_1");
        step(0, 1, 1, 0, 0, 0, 0, 0, 32'h1111_0004, 11'd5, 11'd5, 0, "stall_2");
        step(0, 1, 1, 0, 0, 0, 0, 0, 32'h1111_0004, 11'd5, 11'd5, 0, "stall_3");
        run(32'h1111_0005, 11'd6, 11'd6, 0, "post_stall_5");
        run(32'h1111_0006, 11'd7, 11'd7, 0, "post_stall_6");

        // HALT at PC=7 overridden by a following branch
        run(HALT, 11'd8, 11'd7, 1, "halt_at_7");
        step(0, 1, 0, 1, 11'h20, 0, 0, 0, NOP, 11'd0, 11'h20, 0, "halt_branch_nop");
        run(32'h2222_0020, 11'h21, 11'h21, 0, "halt_branch_target");

        // Stall outranks branch
        step(0, 1, 1, 1, 11'h30, 0, 0, 0, 32'h2222_0020, 11'h21, 11'h21, 0, "stall_branch_1");
        step(0, 1, 1, 1, 11'h30, 0, 0, 0, 32'h2222_0020, 11'h21, 11'h21, 0, "stall_branch_2");
        step(0, 1, 0, 1, 11'h30, 0, 0, 0, NOP, 11'd0, 11'h30, 0, "branch_after_stall");
        run(32'h3333_0030, 11'h31, 11'h31, 0, "branch_after_stall_tgt");

        // PC wrap at 2047
        step(0, 1, 0, 1, 11'h7FF, 0, 0, 0, NOP, 11'd0, 11'h7FF, 0, "branch_to_top");
        run(32'h7FF0_07FF, 11'd0, 11'd0, 0, "wrap_fetch");
        run(32'h2001_0005, 11'd1, 11'd1, 0, "wrap_then_0");

        // Write ignored while pipeline enabled
        step(0, 1, 0, 0, 0, 1, 11'd2, 32'hDEAD_BEEF, 32'h2002_0007, 11'd2, 11'd2, 0, "write_while_en");
        run(32'h0022_1820, 11'd3, 11'd3, 0, "mem_unchanged");

        // Reset mid-run
        step(1, 1, 0, 0, 0, 0, 0, 0, NOP, 11'd0, 11'd0, 0, "reset_mid_run");

        // Reset mid-halt
        run(32'h2001_0005, 11'd1, 11'd1, 0, "rerun_w0");
        run(32'h2002_0007, 11'd2, 11'd2, 0, "rerun_w1");
        run(32'h0022_1820, 11'd3, 11'd3, 0, "rerun_w2");
        run(HALT,          11'd4, 11'd3, 1, "rerun_halt");
        step(1, 1, 0, 0, 0, 0, 0, 0, NOP, 11'd0, 11'd0, 0, "reset_mid_halt");

        // Reset outranks a coincident memory write
        step(1, 0, 0, 0, 0, 1, 11'd0, 32'h5555_5555, NOP, 11'd0, 11'd0, 0, "reset_with_write");
        run(32'h2001_0005, 11'd1, 11'd1, 0, "write_blocked_by_reset");

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge i_clock);
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/top_if.md
# top_if

Instruction-fetch stage of the MIPS pipeline: owns the program counter, the program (instruction) memory and the IF/ID pipeline register, and feeds the instruction-decode stage directly. It redirects the PC on branch/jump requests returned from decode, holds on hazard stalls, and freezes on a fetched HALT word. The program memory is loaded by the debug unit while the pipeline is disabled.

## Interface
- LENGTH_INSTRUCTION, 32, instruction width
- CANT_BITS_ADDR, 11, PC / program-memory word-address width
- RAM_DEPTH, 2048, program-memory depth in words (= 2**CANT_BITS_ADDR)
- HALT_INSTRUCTION, 32'hFFFFFFFF, HALT encoding
- NOP_INSTRUCTION, 32'h00000000, bubble inserted on flush

- i_clock  in  1  clock; all state updates on rising edge
- i_soft_reset  in  1  reset; synchronous, active-high
- i_enable_pipeline  in  1  1 = stage advances; 0 = frozen (debug/step mode)
- i_stall  in  1  hazard-unit bubble request; hold PC and IF/ID
- i_branch_control  in  1  redirect request from decode
- i_branch_dir  in  CANT_BITS_ADDR  redirect target (word address)
- i_write_mem  in  1  debug-unit program-memory write strobe
- i_addr_mem  in  CANT_BITS_ADDR  debug write address
- i_data_mem  in  LENGTH_INSTRUCTION  debug write data
- o_instruction  out  LENGTH_INSTRUCTION  IF/ID instruction
- o_out_adder_pc  out  CANT_BITS_ADDR  IF/ID PC+1 of that instruction
- o_pc  out  CANT_BITS_ADDR  current PC (debug readout)
- o_halted  out  1  stage is in HALTED state

## Operation
- States: RUN, HALTED. Reset → RUN.
- Reset values: PC=0, o_instruction=NOP_INSTRUCTION, o_out_adder_pc=0, o_halted=0. Program memory contents are not cleared by reset.
- Memory write: when i_write_mem=1 and i_enable_pipeline=0, mem[i_addr_mem] <= i_data_mem. i_write_mem is ignored while i_enable_pipeline=1.
- Memory read is asynchronous on PC; the word is captured into IF/ID.
- Per rising edge, with reset low, first matching rule applies:
  1. i_enable_pipeline=0: PC, IF/ID and state hold.
  2. i_stall=1: PC, IF/ID and state hold. Stall outranks branch; decode re-asserts the branch once released.
  3. i_branch_control=1: PC <= i_branch_dir; o_instruction <= NOP; o_out_adder_pc <= 0; state <= RUN. Applies in HALTED too: an older branch overrides a speculatively fetched HALT.
  4. State HALTED: PC holds; o_instruction keeps HALT_INSTRUCTION; o_out_adder_pc holds.
  5. RUN, mem[PC] = HALT: o_instruction <= HALT; o_out_adder_pc <= PC+1; PC holds; state <= HALTED.
  6. RUN otherwise: o_instruction <= mem[PC]; o_out_adder_pc <= PC+1; PC <= PC+1.
- PC+1 is modulo 2**CANT_BITS_ADDR: 2047 wraps to 0 with no flag.
- o_halted = (state == HALTED).

## Timing
- Fetch latency: 1 cycle from PC value to o_instruction.
- Branch: asserted in cycle n → cycle n+1 shows NOP in IF/ID and PC = target → cycle n+2 shows mem[target].
- Stall: IF/ID output stable for every cycle i_stall=1; fetch resumes the cycle after deassertion without loss or duplication.
- HALT: visible on o_instruction 1 cycle after PC reaches it; o_halted rises the same edge.
- Debug write: takes effect the edge it is sampled; the word is readable the next cycle.
- Reset asserted mid-run or mid-halt takes priority over all rules and over memory writes.

## Structure
- Shared package: HALT_INSTRUCTION, NOP_INSTRUCTION, CANT_BITS_ADDR, LENGTH_INSTRUCTION, state encoding (RUN/HALTED). Decode and the debug unit read the same constants.
- One sub-module: memoria_programa (RAM_DEPTH × LENGTH_INSTRUCTION, 1 sync write port, 1 async read port). PC, FSM and IF/ID register stay in top_if.

## Test plan
- Reset, load mem[0..3]=0x20010005,0x20020007,0x00221820,HALT, enable pipeline → o_instruction sequence those four words, o_out_adder_pc 1,2,3,4; o_halted=1 and PC=3 thereafter.
- Run from 0, assert i_branch_control with i_branch_dir=0x010 at PC=2 → next cycle NOP with PC=0x010; following cycle mem[0x010] with o_out_adder_pc=0x011.
- Assert i_stall for 3 cycles at PC=5 → o_instruction=mem[4] and PC=5 held throughout; after release mem[5], then mem[6].
- i_stall and i_branch_control both high → no redirect; drop i_stall keeping branch → redirect the next edge.
- HALT fetched at PC=7, branch to 0x020 asserted the following cycle → o_halted drops, NOP, then mem[0x020].
- PC=2047 normal fetch → o_out_adder_pc=0, PC=0; i_write_mem with pipeline enabled → memory unchanged; reset mid-run → all outputs return to reset values next edge.
